// File: rtl/clk_divider_multi_if.sv
// Control/status bundle for the multi-channel clock divider.
// CLKDIV_SYNC_EN adds the sync_i phase-align input.
interface clk_divider_multi_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 17
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] en_i;
    logic              wr_i;
    logic [CH_W-1:0]   wr_ch_i;
    logic [CNT_W-1:0]  wr_half_i;
`ifdef CLKDIV_SYNC_EN
    logic              sync_i;
`endif
    logic [NUM_CH-1:0] clk_o;
    logic [NUM_CH-1:0] tick_o;
    logic [NUM_CH-1:0] pend_o;

`ifdef CLKDIV_SYNC_EN
    modport master (output en_i, wr_i, wr_ch_i, wr_half_i, sync_i,
                    input  clk_o, tick_o, pend_o);
    modport slave  (input  en_i, wr_i, wr_ch_i, wr_half_i, sync_i,
                    output clk_o, tick_o, pend_o);
`else
    modport master (output en_i, wr_i, wr_ch_i, wr_half_i,
                    input  clk_o, tick_o, pend_o);
    modport slave  (input  en_i, wr_i, wr_ch_i, wr_half_i,
                    output clk_o, tick_o, pend_o);
`endif
endinterface

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider with shadowed, glitch-free ratio updates.
// Optional feature macro CLKDIV_SYNC_EN: sync_i phase-aligns all enabled channels.
module clk_divider_multi #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned CNT_W        = 17,
    parameter int unsigned DEFAULT_HALF = 9999
) (
    input  logic                clk_i,
    input  logic                rst,
    clk_divider_multi_if.slave  bus
);
    localparam int unsigned      CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  half_q   [NUM_CH];
    logic [CNT_W-1:0]  shadow_q [NUM_CH];
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] clk_q;
    logic [NUM_CH-1:0] tick_q;
    logic              sync_c;
    logic              wr_ok_c;

`ifdef CLKDIV_SYNC_EN
    assign sync_c = bus.sync_i;
`else
    assign sync_c = 1'b0;
`endif

    // Out-of-range channel numbers are dropped silently.
    assign wr_ok_c = bus.wr_i && (32'(bus.wr_ch_i) < NUM_CH);

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                cnt_q[c]    <= '0;
                half_q[c]   <= HALF_RST;
                shadow_q[c] <= HALF_RST;
            end
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (!bus.en_i[c] || sync_c) begin
                    // Idle/realign: park low and take any pending ratio right away.
                    cnt_q[c]  <= '0;
                    clk_q[c]  <= 1'b0;
                    tick_q[c] <= 1'b0;
                    if (pend_q[c]) begin
                        half_q[c] <= shadow_q[c];
                        pend_q[c] <= 1'b0;
                    end
                end else if (cnt_q[c] >= half_q[c]) begin
                    cnt_q[c]  <= '0;
                    clk_q[c]  <= ~clk_q[c];
                    tick_q[c] <= 1'b1;
                    // New ratio only at the falling edge that closes a full period.
                    if (clk_q[c] && pend_q[c]) begin
                        half_q[c] <= shadow_q[c];
                        pend_q[c] <= 1'b0;
                    end
                end else begin
                    cnt_q[c]  <= cnt_q[c] + CNT_W'(1);
                    tick_q[c] <= 1'b0;
                end

                // Later assignment wins: a write beside an apply leaves pend set.
                if (wr_ok_c && (bus.wr_ch_i == CH_W'(c))) begin
                    shadow_q[c] <= bus.wr_half_i;
                    pend_q[c]   <= 1'b1;
                end
            end
        end
    end

    assign bus.clk_o  = clk_q;
    assign bus.tick_o = tick_q;
    assign bus.pend_o = pend_q;

endmodule
